// File: rtl/constants_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : constants_pkg
//  Brief    : Core-wide width constants and the default instruction-queue depth.
//  Revision : 1.0
// ============================================================================
package constants_pkg;
  localparam int ARCH_LEN = 32;
  localparam int INST_LEN = 32;
  localparam int IQ_DEPTH = 4;
endpackage
`default_nettype wire

// File: rtl/structure_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : structure_pkg
//  Brief    : Shared pipeline packet types.
//  Revision : 1.0
// ============================================================================
package structure_pkg;
  import constants_pkg::*;

  typedef struct packed {
    logic [ARCH_LEN-1:0] pc;
    logic [INST_LEN-1:0] inst;
  } fetch_pkt_t;
endpackage
`default_nettype wire

// File: rtl/fetch_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_inst_queue
//  Brief    : FIFO of {pc, inst} between fetch and decode with full-based
//             fetch stall, valid/ready decode handshake and sticky overflow flag.
//  Revision : 1.0
// ============================================================================
module fetch_inst_queue
  import constants_pkg::*;
  import structure_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_in,
  input  logic                       push_valid_in,
  input  logic [ARCH_LEN-1:0]        push_pc_in,
  input  logic [INST_LEN-1:0]        push_inst_in,
  output logic                       stall_fet_out,
  output logic                       dec_valid_out,
  input  logic                       dec_ready_in,
  output fetch_pkt_t                 dec_pkt_out,
  output logic [$clog2(DEPTH):0]     count_out,
  output logic                       overflow_err_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  fetch_pkt_t             r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_overflow_err;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  fetch_pkt_t             w_push_pkt;

  // Full is derived from the registered count only, so a same-cycle pop
  // never makes room for a push.
  assign w_full     = (r_count == C_DEPTH);
  assign w_empty    = (r_count == '0);
  assign w_push     = push_valid_in && !w_full;
  assign w_pop      = !w_empty && dec_ready_in;
  assign w_push_pkt = '{pc: push_pc_in, inst: push_inst_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_overflow_err <= 1'b0;
    end else if (flush_in) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_overflow_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
      if (push_valid_in && w_full) r_overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush_in) r_mem[r_wr_ptr] <= w_push_pkt;
  end

  assign stall_fet_out    = w_full;
  assign dec_valid_out    = !w_empty;
  assign dec_pkt_out      = w_empty ? '0 : r_mem[r_rd_ptr];
  assign count_out        = r_count;
  assign overflow_err_out = r_overflow_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_inst_queue
//  Brief    : Directed self-checking bench for fetch_inst_queue.
//  Revision : 1.0
// ============================================================================
module tb_fetch_inst_queue;
  import constants_pkg::*;
  import structure_pkg::*;

  logic                clk;
  logic                rst;
  logic                flush_in;
  logic                push_valid_in;
  logic [ARCH_LEN-1:0] push_pc_in;
  logic [INST_LEN-1:0] push_inst_in;
  logic                stall_fet_out;
  logic                dec_valid_out;
  logic                dec_ready_in;
  fetch_pkt_t          dec_pkt_out;
  logic [2:0]          count_out;
  logic                overflow_err_out;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_inst_queue #(.DEPTH(4)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .flush_in         (flush_in),
    .push_valid_in    (push_valid_in),
    .push_pc_in       (push_pc_in),
    .push_inst_in     (push_inst_in),
    .stall_fet_out    (stall_fet_out),
    .dec_valid_out    (dec_valid_out),
    .dec_ready_in     (dec_ready_in),
    .dec_pkt_out      (dec_pkt_out),
    .count_out        (count_out),
    .overflow_err_out (overflow_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [INST_LEN-1:0] inst_of(input logic [ARCH_LEN-1:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic v, input logic [ARCH_LEN-1:0] pc);
    push_valid_in = v;
    push_pc_in    = pc;
    push_inst_in  = inst_of(pc);
  endtask

  task automatic check_head(input string tag, input logic [ARCH_LEN-1:0] pc);
    check_eq({tag, "_valid"}, 64'(dec_valid_out), 64'd1);
    check_eq({tag, "_pc"},    64'(dec_pkt_out.pc), 64'(pc));
    check_eq({tag, "_inst"},  64'(dec_pkt_out.inst), 64'(inst_of(pc)));
  endtask

  initial begin
    rst = 1'b1; flush_in = 1'b0; dec_ready_in = 1'b0;
    drive_push(1'b0, '0);
    step(); step();

    check_eq("rst_count", 64'(count_out), 64'd0);
    check_eq("rst_valid", 64'(dec_valid_out), 64'd0);
    check_eq("rst_stall", 64'(stall_fet_out), 64'd0);
    check_eq("rst_pkt",   64'(dec_pkt_out), 64'd0);
    check_eq("rst_err",   64'(overflow_err_out), 64'd0);

    // Two entries, then async reset between edges
    rst = 1'b0;
    drive_push(1'b1, 32'h40); step();
    drive_push(1'b1, 32'h44); step();
    drive_push(1'b0, '0);
    check_eq("pre_rst_count", 64'(count_out), 64'd2);
    check_head("pre_rst_head", 32'h40);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_valid", 64'(dec_valid_out), 64'd0);
    check_eq("async_rst_count", 64'(count_out), 64'd0);
    step();
    rst = 1'b0;
    step();

    // Fill to full, then a dropped fifth push
    for (int i = 0; i < 4; i++) begin
      drive_push(1'b1, 32'(i * 4));
      step();
    end
    check_eq("fill_count", 64'(count_out), 64'd4);
    check_eq("fill_stall", 64'(stall_fet_out), 64'd1);
    check_eq("fill_err",   64'(overflow_err_out), 64'd0);
    drive_push(1'b1, 32'h10); step();
    drive_push(1'b0, '0);
    check_eq("ovf_count", 64'(count_out), 64'd4);
    check_eq("ovf_err",   64'(overflow_err_out), 64'd1);

    // Drain in order
    dec_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("drain%0d", i), 32'(i * 4));
      step();
    end
    check_eq("drain_valid", 64'(dec_valid_out), 64'd0);
    check_eq("drain_count", 64'(count_out), 64'd0);
    check_eq("drain_err_sticky", 64'(overflow_err_out), 64'd1);

    // Streaming push+pop for 20 cycles
    for (int k = 0; k < 20; k++) begin
      drive_push(1'b1, 32'h1000 + 32'(k * 4));
      if (k > 0) check_head($sformatf("stream%0d", k), 32'h1000 + 32'((k - 1) * 4));
      step();
      check_eq($sformatf("stream_count%0d", k), 64'(count_out), 64'd1);
    end
    drive_push(1'b0, '0);
    check_head("stream_last", 32'h1000 + 32'(19 * 4));
    step();
    check_eq("stream_end_count", 64'(count_out), 64'd0);

    // Flush with same-cycle push
    dec_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(1'b1, 32'h200 + 32'(i * 4));
      step();
    end
    check_eq("preflush_count", 64'(count_out), 64'd3);
    flush_in = 1'b1;
    drive_push(1'b1, 32'h100);
    step();
    flush_in = 1'b0;
    drive_push(1'b0, '0);
    check_eq("flush_count", 64'(count_out), 64'd0);
    check_eq("flush_valid", 64'(dec_valid_out), 64'd0);
    check_eq("flush_err",   64'(overflow_err_out), 64'd0);
    step();
    check_eq("flush_no_0x100", 64'(dec_valid_out), 64'd0);

    // Push while full with a same-cycle pop
    for (int i = 0; i < 4; i++) begin
      drive_push(1'b1, 32'h30 + 32'(i * 4));
      step();
    end
    check_eq("full2_count", 64'(count_out), 64'd4);
    drive_push(1'b1, 32'h20);
    dec_ready_in = 1'b1;
    step();
    drive_push(1'b0, '0);
    check_eq("pwf_count", 64'(count_out), 64'd3);
    check_eq("pwf_err",   64'(overflow_err_out), 64'd1);
    for (int i = 1; i < 4; i++) begin
      check_head($sformatf("pwf_drain%0d", i), 32'h30 + 32'(i * 4));
      step();
    end
    check_eq("pwf_empty", 64'(dec_valid_out), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
